// File: rtl/stack_mem_pkg.sv
// ---------------------------------------------------------------------------
// stack_mem_pkg
// Shared definitions for the data stack memory: default widths, stack
// pointer limits and the interrupt save/restore sequencer state encoding.
// ---------------------------------------------------------------------------
package stack_mem_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_ADDR_W = 15;
   localparam int DEF_PC_W   = 2 * DEF_DATA_W;
   localparam int DEF_FLAG_W = 3;

   // sp counts down from DEPTH (empty) to 0 (full)
   localparam int SP_FULL  = 0;
   localparam int SP_EMPTY = 1 << DEF_ADDR_W;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SV_HI = 3'd1,
      ST_SV_LO = 3'd2,
      ST_SV_FL = 3'd3,
      ST_RS_FL = 3'd4,
      ST_RS_LO = 3'd5,
      ST_RS_HI = 3'd6
   } stk_state_e;

   // Empty-stack pointer value for an arbitrary address width
   function automatic int sp_empty_of(input int addr_w);
      return 1 << addr_w;
   endfunction

endpackage

// File: rtl/stack_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// stack_ctrl_fsm
// Owns the stack pointer, overflow/underflow detection and the interrupt
// save/restore sequencer. Decides, every cycle, which single stack push
// and/or pop reaches the storage array in the parent.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   i_push, i_pop      external stack requests (ignored while busy)
//   i_save_req         start PC/flags save (3 pushes)
//   i_restore_req      start PC/flags restore (3 pops)
//   i_pc, i_flags      state latched on an accepted save
//   i_push_data        data for external pushes
//   o_stk_we/waddr/wdata  stack write port
//   o_stk_raddr        stack read address (current top)
//   o_ext_pop_req      external pop requested this cycle (masks rd_en)
//   o_ext_pop_ok       external pop accepted -> rd_data
//   o_ld_fl/lo/hi      sequencer pop accepted for flags / pc low / pc high
//   o_busy, o_sp, o_overflow, o_underflow  status
// ---------------------------------------------------------------------------
module stack_ctrl_fsm
   import stack_mem_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int PC_W   = DEF_PC_W,
   parameter int FLAG_W = DEF_FLAG_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_push,
   input  logic              i_pop,
   input  logic              i_save_req,
   input  logic              i_restore_req,
   input  logic [PC_W-1:0]   i_pc,
   input  logic [FLAG_W-1:0] i_flags,
   input  logic [DATA_W-1:0] i_push_data,
   output logic              o_stk_we,
   output logic [ADDR_W-1:0] o_stk_waddr,
   output logic [DATA_W-1:0] o_stk_wdata,
   output logic [ADDR_W-1:0] o_stk_raddr,
   output logic              o_ext_pop_req,
   output logic              o_ext_pop_ok,
   output logic              o_ld_fl,
   output logic              o_ld_lo,
   output logic              o_ld_hi,
   output logic              o_busy,
   output logic [ADDR_W:0]   o_sp,
   output logic              o_overflow,
   output logic              o_underflow
);

   localparam logic [ADDR_W:0]   LP_EMPTY = (ADDR_W+1)'(sp_empty_of(ADDR_W));
   localparam logic [ADDR_W:0]   LP_FULL  = (ADDR_W+1)'(SP_FULL);
   localparam logic [ADDR_W:0]   LP_ONE   = 1;
   localparam logic [ADDR_W-1:0] LP_ONE_A = 1;

   stk_state_e        r_state, w_next;
   logic [ADDR_W:0]   r_sp, w_sp_next;
   logic [PC_W-1:0]   r_pc;
   logic [FLAG_W-1:0] r_flags;
   logic              r_ovf, r_udf;

   logic              w_full, w_empty;
   logic              w_ext, w_push_req, w_pop_req;
   logic              w_replace, w_push_ok, w_pop_ok, w_ovf, w_udf;
   logic [DATA_W-1:0] w_push_data, w_fl_ext;

   assign w_full  = (r_sp == LP_FULL);
   assign w_empty = (r_sp == LP_EMPTY);

   // State register (plus the datapath state that moves with it)
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_sp    <= LP_EMPTY;
         r_ovf   <= 1'b0;
         r_udf   <= 1'b0;
         r_pc    <= '0;
         r_flags <= '0;
      end else begin
         r_state <= w_next;
         r_sp    <= w_sp_next;
         r_ovf   <= w_ovf;
         r_udf   <= w_udf;
         if (r_state == ST_IDLE && i_save_req) begin
            r_pc    <= i_pc;
            r_flags <= i_flags;
         end
      end
   end

   // Next state: any blocked push/pop inside a sequence aborts it
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (i_save_req)         w_next = ST_SV_HI;
            else if (i_restore_req) w_next = ST_RS_FL;
         end
         ST_SV_HI: w_next = w_ovf ? ST_IDLE : ST_SV_LO;
         ST_SV_LO: w_next = w_ovf ? ST_IDLE : ST_SV_FL;
         ST_SV_FL: w_next = ST_IDLE;
         ST_RS_FL: w_next = w_udf ? ST_IDLE : ST_RS_LO;
         ST_RS_LO: w_next = w_udf ? ST_IDLE : ST_RS_HI;
         ST_RS_HI: w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   // Outputs: stack operation selection and pointer update
   always_comb begin
      w_ext       = 1'b0;
      w_push_req  = 1'b0;
      w_pop_req   = 1'b0;
      w_push_data = i_push_data;
      w_fl_ext    = '0;
      w_fl_ext[FLAG_W-1:0] = r_flags;
      unique case (r_state)
         ST_IDLE: begin
            // an accepted save/restore swallows same-cycle push/pop
            if (!i_save_req && !i_restore_req) begin
               w_ext      = 1'b1;
               w_push_req = i_push;
               w_pop_req  = i_pop;
            end
         end
         ST_SV_HI: begin
            w_push_req  = 1'b1;
            w_push_data = r_pc[PC_W-1:DATA_W];
         end
         ST_SV_LO: begin
            w_push_req  = 1'b1;
            w_push_data = r_pc[DATA_W-1:0];
         end
         ST_SV_FL: begin
            w_push_req  = 1'b1;
            w_push_data = w_fl_ext;
         end
         ST_RS_FL, ST_RS_LO, ST_RS_HI: w_pop_req = 1'b1;
         default: ;
      endcase

      // push+pop on a non-empty stack overwrites the top in place; on an
      // empty stack the pop underflows and the push proceeds normally
      w_replace = w_push_req && w_pop_req && !w_empty;
      w_push_ok = w_push_req && (w_replace || !w_full);
      w_pop_ok  = w_pop_req && !w_empty;
      w_ovf     = w_push_req && !w_push_ok;
      w_udf     = w_pop_req && w_empty;

      if (w_replace)      w_sp_next = r_sp;
      else if (w_push_ok) w_sp_next = r_sp - LP_ONE;
      else if (w_pop_ok)  w_sp_next = r_sp + LP_ONE;
      else                w_sp_next = r_sp;

      o_stk_we      = w_push_ok;
      o_stk_waddr   = w_replace ? r_sp[ADDR_W-1:0] : (r_sp[ADDR_W-1:0] - LP_ONE_A);
      o_stk_wdata   = w_push_data;
      o_stk_raddr   = r_sp[ADDR_W-1:0];
      o_ext_pop_req = w_ext && i_pop;
      o_ext_pop_ok  = w_ext && w_pop_ok;
      o_ld_fl       = (r_state == ST_RS_FL) && w_pop_ok;
      o_ld_lo       = (r_state == ST_RS_LO) && w_pop_ok;
      o_ld_hi       = (r_state == ST_RS_HI) && w_pop_ok;
      o_busy        = (r_state != ST_IDLE);
   end

   assign o_sp        = r_sp;
   assign o_overflow  = r_ovf;
   assign o_underflow = r_udf;

endmodule

// File: rtl/data_stack_mem.sv
// ---------------------------------------------------------------------------
// data_stack_mem
// Word memory used both as a random-access store and as a downward-growing
// stack, with a hardware sequencer that saves/restores a PC + flags frame.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   rd_en, rd_addr                 random read  -> rd_data/rd_valid next cycle
//   wr_en, wr_addr, wr_data        random write (wr_data also feeds push)
//   push, pop                      stack access (pop result -> rd_data)
//   save_req, pc_in, flags_in      push PC high, PC low, flags
//   restore_req                    pop flags, PC low, PC high
//   restore_pc, restore_flags, restore_valid   restored frame
//   busy, sp, overflow, underflow  status
// ---------------------------------------------------------------------------
module data_stack_mem
   import stack_mem_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int PC_W   = DEF_PC_W,
   parameter int FLAG_W = DEF_FLAG_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              push,
   input  logic              pop,
   input  logic              save_req,
   input  logic              restore_req,
   input  logic [PC_W-1:0]   pc_in,
   input  logic [FLAG_W-1:0] flags_in,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic [PC_W-1:0]   restore_pc,
   output logic [FLAG_W-1:0] restore_flags,
   output logic              restore_valid,
   output logic              busy,
   output logic [ADDR_W:0]   sp,
   output logic              overflow,
   output logic              underflow
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [FLAG_W-1:0] r_rs_fl;
   logic [DATA_W-1:0] r_rs_lo;

   logic              w_stk_we;
   logic [ADDR_W-1:0] w_stk_waddr, w_stk_raddr;
   logic [DATA_W-1:0] w_stk_wdata;
   logic              w_ext_pop_req, w_ext_pop_ok;
   logic              w_ld_fl, w_ld_lo, w_ld_hi;

   stack_ctrl_fsm #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_W(PC_W), .FLAG_W(FLAG_W)
   ) u_ctrl (
      .clk          (clk),
      .rst          (rst),
      .i_push       (push),
      .i_pop        (pop),
      .i_save_req   (save_req),
      .i_restore_req(restore_req),
      .i_pc         (pc_in),
      .i_flags      (flags_in),
      .i_push_data  (wr_data),
      .o_stk_we     (w_stk_we),
      .o_stk_waddr  (w_stk_waddr),
      .o_stk_wdata  (w_stk_wdata),
      .o_stk_raddr  (w_stk_raddr),
      .o_ext_pop_req(w_ext_pop_req),
      .o_ext_pop_ok (w_ext_pop_ok),
      .o_ld_fl      (w_ld_fl),
      .o_ld_lo      (w_ld_lo),
      .o_ld_hi      (w_ld_hi),
      .o_busy       (busy),
      .o_sp         (sp),
      .o_overflow   (overflow),
      .o_underflow  (underflow)
   );

   // Storage: never reset, and frozen while rst is high so an interrupted
   // save leaves no further words behind. The stack write is issued last so
   // it wins an address collision with the random write.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (wr_en)    r_mem[wr_addr]     <= wr_data;
         if (w_stk_we) r_mem[w_stk_waddr] <= w_stk_wdata;
      end
   end

   // Registered reads; reads see pre-write contents of the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data       <= '0;
         rd_valid      <= 1'b0;
         restore_pc    <= '0;
         restore_flags <= '0;
         restore_valid <= 1'b0;
         r_rs_fl       <= '0;
         r_rs_lo       <= '0;
      end else begin
         rd_valid      <= 1'b0;
         restore_valid <= 1'b0;
         // a pop request (even a blocked one) takes the read port from rd_en
         if (w_ext_pop_req) begin
            if (w_ext_pop_ok) begin
               rd_data  <= r_mem[w_stk_raddr];
               rd_valid <= 1'b1;
            end
         end else if (rd_en) begin
            rd_data  <= r_mem[rd_addr];
            rd_valid <= 1'b1;
         end
         if (w_ld_fl) r_rs_fl <= r_mem[w_stk_raddr][FLAG_W-1:0];
         if (w_ld_lo) r_rs_lo <= r_mem[w_stk_raddr];
         // frame is published in one step so restore_pc/flags never tear
         if (w_ld_hi) begin
            restore_pc    <= {r_mem[w_stk_raddr], r_rs_lo};
            restore_flags <= r_rs_fl;
            restore_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_data_stack_mem.sv
module tb_data_stack_mem;

   localparam int DW = 16, AW = 3, PW = 32, FW = 3;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          rst, rd_en, wr_en, push, pop, save_req, restore_req;
   logic [AW-1:0] rd_addr, wr_addr;
   logic [DW-1:0] wr_data, rd_data;
   logic [PW-1:0] pc_in, restore_pc;
   logic [FW-1:0] flags_in, restore_flags;
   logic          rd_valid, restore_valid, busy, overflow, underflow;
   logic [AW:0]   sp;

   data_stack_mem #(.DATA_W(DW), .ADDR_W(AW), .PC_W(PW), .FLAG_W(FW)) dut (
      .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .wr_en(wr_en),
      .wr_addr(wr_addr), .wr_data(wr_data), .push(push), .pop(pop),
      .save_req(save_req), .restore_req(restore_req), .pc_in(pc_in),
      .flags_in(flags_in), .rd_data(rd_data), .rd_valid(rd_valid),
      .restore_pc(restore_pc), .restore_flags(restore_flags),
      .restore_valid(restore_valid), .busy(busy), .sp(sp),
      .overflow(overflow), .underflow(underflow));

   always #5 clk = ~clk;

   typedef struct {
      bit            is_push;
      logic [DW-1:0] data;
      int            slot;     // 1 flags, 2 pc low, 3 pc high
   } op_t;

   typedef struct {
      logic [AW:0]   sp;
      bit            busy, ovf, udf, rdv, rsv;
      logic [DW-1:0] rdd;
      logic [PW-1:0] pc;
      logic [FW-1:0] fl;
   } st_t;

   // reference model: stack as an array + pointer, sequencer as a list of
   // pending stack operations
   logic [DW-1:0] m_mem [DEPTH];
   int            m_sp;
   op_t           ops[$];
   logic [DW-1:0] m_rdd, m_tlo;
   logic [PW-1:0] m_pc;
   logic [FW-1:0] m_fl, m_tfl;

   st_t              q_st[$];
   logic [DW-1:0]    q_rd[$];
   logic [PW+FW-1:0] q_rs[$];

   int checks = 0, errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic model_step();
      st_t s;
      op_t op;
      logic [DW-1:0] val = '0, pdata;
      bit fsm, ext_pop = 0, dpush = 0, dpop = 0, pok = 0, wok = 0;
      bit ovf = 0, udf = 0, rdv = 0, rsv = 0;
      int waddr = 0, slot = 0, old;
      if (rst) begin
         m_sp = DEPTH; ops.delete();
         m_rdd = '0; m_pc = '0; m_fl = '0;
         s.sp = (AW+1)'(DEPTH); s.busy = 0; s.ovf = 0; s.udf = 0; s.rdv = 0; s.rsv = 0;
         s.rdd = '0; s.pc = '0; s.fl = '0;
         q_st.push_back(s);
         return;
      end
      pdata = wr_data;
      fsm = (ops.size() > 0);
      if (fsm) begin
         op = ops.pop_front();
         dpush = op.is_push; dpop = !op.is_push; pdata = op.data; slot = op.slot;
      end else if (save_req) begin
         ops.push_back('{1'b1, pc_in[31:16], 0});
         ops.push_back('{1'b1, pc_in[15:0], 0});
         ops.push_back('{1'b1, {13'd0, flags_in}, 0});
      end else if (restore_req) begin
         ops.push_back('{1'b0, 16'd0, 1});
         ops.push_back('{1'b0, 16'd0, 2});
         ops.push_back('{1'b0, 16'd0, 3});
      end else begin
         dpush = push; dpop = pop; ext_pop = pop;
      end
      old = m_sp;
      if (dpush && dpop && old != DEPTH) begin
         val = m_mem[old]; pok = 1; wok = 1; waddr = old;
      end else begin
         if (dpop) begin
            if (old == DEPTH) udf = 1;
            else begin val = m_mem[old]; pok = 1; m_sp = old + 1; end
         end
         if (dpush) begin
            if (old == 0) ovf = 1;
            else begin wok = 1; waddr = old - 1; m_sp = old - 1; end
         end
      end
      if (fsm && (ovf || udf)) ops.delete();
      if (fsm && dpop && pok) begin
         case (slot)
            1: m_tfl = val[FW-1:0];
            2: m_tlo = val;
            default: begin m_pc = {val, m_tlo}; m_fl = m_tfl; rsv = 1; end
         endcase
      end
      if (ext_pop) begin
         if (pok) begin m_rdd = val; rdv = 1; end
      end else if (rd_en) begin
         m_rdd = m_mem[rd_addr]; rdv = 1;
      end
      if (wr_en) m_mem[wr_addr] = wr_data;
      if (wok)   m_mem[waddr] = pdata;
      s.sp = (AW+1)'(m_sp); s.busy = (ops.size() > 0); s.ovf = ovf; s.udf = udf;
      s.rdv = rdv; s.rsv = rsv; s.rdd = m_rdd; s.pc = m_pc; s.fl = m_fl;
      q_st.push_back(s);
      if (rdv) q_rd.push_back(m_rdd);
      if (rsv) q_rs.push_back({m_pc, m_fl});
   endtask

   // monitor: compares every post-edge cycle against the model
   initial begin
      st_t s;
      forever begin
         @(posedge clk);
         #1;
         if (q_st.size() > 0) begin
            s = q_st.pop_front();
            chk("sp", sp, s.sp);
            chk("busy", busy, s.busy);
            chk("overflow", overflow, s.ovf);
            chk("underflow", underflow, s.udf);
            chk("rd_valid", rd_valid, s.rdv);
            chk("rd_data_hold", rd_data, s.rdd);
            chk("restore_valid", restore_valid, s.rsv);
            chk("restore_frame_hold", {restore_pc, restore_flags}, {s.pc, s.fl});
         end
         if (rd_valid) begin
            if (q_rd.size() == 0) begin
               checks++; errors++;
               $display("FAIL rd_sb got unexpected data 0x%0h expected none", rd_data);
            end else chk("rd_sb", rd_data, q_rd.pop_front());
         end
         if (restore_valid) begin
            if (q_rs.size() == 0) begin
               checks++; errors++;
               $display("FAIL rs_sb got unexpected pc 0x%0h expected none", restore_pc);
            end else chk("rs_sb", {restore_pc, restore_flags}, q_rs.pop_front());
         end
      end
   end

   task automatic clr();
      rd_en = 0; wr_en = 0; push = 0; pop = 0; save_req = 0; restore_req = 0;
      rd_addr = '0; wr_addr = '0; wr_data = '0;
   endtask

   task automatic tick();
      model_step();
      @(negedge clk);
   endtask

   initial begin
      clr(); rst = 1; pc_in = '0; flags_in = '0;
      @(negedge clk);
      tick(); tick();
      chk("rst_sp", sp, DEPTH);
      chk("rst_busy", busy, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_restore_valid", restore_valid, 0);
      chk("rst_restore_pc", restore_pc, 0);
      chk("rst_restore_flags", restore_flags, 0);
      chk("rst_ovf_udf", {overflow, underflow}, 0);
      rst = 0;
      for (int i = 0; i < DEPTH; i++) begin
         wr_en = 1; wr_addr = AW'(i); wr_data = 16'hC000 + 16'(i); tick();
      end
      clr();

      // push two, pop two
      push = 1; wr_data = 16'h1111; tick();
      wr_data = 16'h2222; tick();
      clr(); chk("push2_sp", sp, DEPTH - 2);
      pop = 1; tick();
      chk("pop1_data", rd_data, 16'h2222); chk("pop1_valid", rd_valid, 1);
      tick();
      chk("pop2_data", rd_data, 16'h1111); chk("pop2_sp", sp, DEPTH);
      clr(); tick();
      chk("pop_valid_drop", rd_valid, 0);

      // underflow
      pop = 1; tick(); clr();
      chk("udf_pulse", underflow, 1); chk("udf_rd_valid", rd_valid, 0); chk("udf_sp", sp, DEPTH);
      tick(); chk("udf_clear", underflow, 0);

      // overflow on the (DEPTH+1)th push
      push = 1;
      for (int i = 0; i < DEPTH; i++) begin wr_data = 16'(i); tick(); end
      chk("full_sp", sp, 0); chk("full_no_ovf", overflow, 0);
      wr_data = 16'hDEAD; tick(); clr();
      chk("ovf_pulse", overflow, 1); chk("ovf_sp", sp, 0);
      tick(); chk("ovf_clear", overflow, 0);
      rst = 1; tick(); rst = 0;

      // save frame
      save_req = 1; pc_in = 32'h0001_ABCD; flags_in = 3'b101; tick(); clr();
      chk("save_busy1", busy, 1); tick();
      chk("save_busy2", busy, 1); tick();
      chk("save_busy3", busy, 1); tick();
      chk("save_done", busy, 0); chk("save_sp", sp, DEPTH - 3);
      rd_en = 1; rd_addr = 3'd7; tick(); chk("save_m7", rd_data, 16'h0001);
      rd_addr = 3'd6; tick(); chk("save_m6", rd_data, 16'hABCD);
      rd_addr = 3'd5; tick(); chk("save_m5", rd_data, 16'h0005);
      clr();

      // restore frame
      restore_req = 1; tick(); clr();
      tick(); tick(); tick();
      chk("rs_valid", restore_valid, 1); chk("rs_pc", restore_pc, 32'h0001_ABCD);
      chk("rs_flags", restore_flags, 3'b101); chk("rs_sp", sp, DEPTH);
      tick();
      chk("rs_pulse_end", restore_valid, 0); chk("rs_pc_hold", restore_pc, 32'h0001_ABCD);

      // replace-top
      push = 1; wr_data = 16'h0055; tick();
      pop = 1; wr_data = 16'h00AA; tick(); clr();
      chk("rep_data", rd_data, 16'h0055); chk("rep_valid", rd_valid, 1); chk("rep_sp", sp, DEPTH - 1);
      pop = 1; tick(); clr();
      chk("rep_top", rd_data, 16'h00AA); chk("rep_sp2", sp, DEPTH);

      // reset in the middle of a save
      save_req = 1; pc_in = 32'h1234_5678; flags_in = 3'b010; tick(); clr();
      tick();
      rst = 1; tick();
      chk("rst_mid_busy", busy, 0); chk("rst_mid_sp", sp, DEPTH); chk("rst_mid_rsv", restore_valid, 0);
      rst = 0;
      rd_en = 1; rd_addr = 3'd6; tick(); chk("rst_mid_m6_kept", rd_data, 16'hABCD);
      rd_addr = 3'd7; tick(); chk("rst_mid_m7_partial", rd_data, 16'h1234);
      clr(); tick();

      // randomized traffic against the model
      for (int n = 0; n < 4000; n++) begin
         rst         = ($urandom_range(0, 299) == 0);
         push        = ($urandom_range(0, 99) < 35);
         pop         = ($urandom_range(0, 99) < 30);
         save_req    = ($urandom_range(0, 99) < 4);
         restore_req = ($urandom_range(0, 99) < 4);
         rd_en       = ($urandom_range(0, 99) < 30);
         wr_en       = ($urandom_range(0, 99) < 20);
         rd_addr     = AW'($urandom_range(0, DEPTH - 1));
         wr_addr     = AW'($urandom_range(0, DEPTH - 1));
         wr_data     = DW'($urandom);
         pc_in       = $urandom;
         flags_in    = FW'($urandom_range(0, 7));
         tick();
      end
      clr(); rst = 0;
      tick(); tick();
      chk("sb_drain", q_st.size() + q_rd.size() + q_rs.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
